// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one character at a time from NUM_REQ
// requesters into a single UART transmitter and supervises its busy flag.
//
// Handshake: a requester holds req_valid/req_data stable until it sees its
// req_ready bit high for one cycle. That pulse coincides with tx_start and
// means the character has been taken; the requester may then drop
// req_valid or present its next character. The transmitter is expected to
// raise tx_busy within BUSY_TIMEOUT cycles of tx_start and drop it once the
// character is on the line.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 4,
  localparam int GID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  output logic                          grant_valid,
  output logic [GID_W-1:0]              grant_id,
  output logic                          tx_done,
  output logic                          timeout_err,
  output logic [1:0]                    state_dbg
);

  localparam int CNT_W = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LAUNCH    = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [GID_W-1:0] GID_LAST = GID_W'(NUM_REQ - 1);

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [GID_W-1:0]      rr_ptr;
  logic [CNT_W-1:0]      busy_cnt;

  logic                  win_found;
  logic [GID_W-1:0]      win_id;
  logic [GID_W-1:0]      cand;
  int                    scan_idx;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  arb_fire;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  // Unpack the flat request data bus into one entry per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: first valid index at or above rr_ptr, wrapping to 0.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      cand = GID_W'(scan_idx);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign win_data = data_arr[win_id];

  // A grant is taken only from IDLE, with the transmitter free and enabled;
  // win_found doubles as the "any request pending" term.
  assign arb_fire = enable && !tx_busy && win_found;

  // Next-state selection; an unknown encoding falls back to IDLE.
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:      state_nxt = arb_fire ? S_LAUNCH : S_IDLE;
      S_LAUNCH:    state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (tx_busy)                    state_nxt = S_WAIT_DONE;
        else if (busy_cnt == CNT_LAST)  state_nxt = S_IDLE;
        else                            state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_DONE: state_nxt = tx_busy ? S_WAIT_DONE : S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // State, round-robin pointer, captured grant and busy-wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      tx_data  <= '0;
      busy_cnt <= '0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE) && arb_fire) begin
        tx_data  <= win_data;
        grant_id <= win_id;
        rr_ptr   <= (win_id == GID_LAST) ? '0 : win_id + 1'b1;
      end
      // Counter runs only while waiting for busy; it is zero on entry.
      if (state == S_WAIT_BUSY) busy_cnt <= busy_cnt + 1'b1;
      else                      busy_cnt <= '0;
    end
  end

  // Output decode. Start/ready follow LAUNCH; the completion pulses are
  // raised in the same cycle that decides the return to IDLE.
  always_comb begin
    tx_start    = (state == S_LAUNCH);
    grant_valid = (state == S_LAUNCH) || (state == S_WAIT_BUSY) ||
                  (state == S_WAIT_DONE);
    req_ready   = '0;
    if (state == S_LAUNCH) req_ready[grant_id] = 1'b1;
    tx_done     = (state == S_WAIT_DONE) && !tx_busy;
    timeout_err = (state == S_WAIT_BUSY) && !tx_busy && (busy_cnt == CNT_LAST);
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a transfer-level reference model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BT = 4;
  localparam int GW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic            enable;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            tx_start;
  logic [DW-1:0]   tx_data;
  logic            tx_busy;
  logic            grant_valid;
  logic [GW-1:0]   grant_id;
  logic            tx_done;
  logic            timeout_err;
  logic [1:0]      state_dbg;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_valid(grant_valid), .grant_id(grant_id),
    .tx_done(tx_done), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard of characters the model says must be launched, in order.
  logic [DW-1:0] exp_q[$];

  // Observation logs used by the directed scenarios.
  int start_cyc[$];
  int start_gid[$];
  int start_dat[$];
  int done_cyc[$];
  int to_cyc[$];
  int overlap_cnt = 0;

  task automatic clear_logs();
    start_cyc.delete(); start_gid.delete(); start_dat.delete();
    done_cyc.delete(); to_cyc.delete();
  endtask

  // Values seen in the previous cycle, used by the driver to react.
  logic         s_start = 1'b0;
  logic [N-1:0] s_ready = '0;

  // ---------------- reference model ----------------
  // A transfer is tracked by its age in cycles since launch (age 0 = the
  // launch cycle) and whether the transmitter has acknowledged with busy.
  bit m_active    = 0;
  bit m_busy_seen = 0;
  int m_age       = 0;
  int m_rr        = 0;
  int m_gid       = 0;

  task automatic model_reset();
    m_active = 0; m_busy_seen = 0; m_age = 0; m_rr = 0; m_gid = 0;
    exp_q.delete();
  endtask

  task automatic model_cycle();
    bit           e_start, e_done, e_to, found;
    logic [N-1:0] e_ready;
    int           idx;
    e_start = m_active && (m_age == 0);
    e_ready = '0;
    if (e_start) e_ready[m_gid] = 1'b1;
    e_done  = m_active && m_busy_seen && !tx_busy;
    e_to    = m_active && !m_busy_seen && (m_age == BT) && !tx_busy;

    check("grant_valid", grant_valid, m_active);
    check("tx_start", tx_start, e_start);
    check("req_ready", req_ready, e_ready);
    check("grant_id", grant_id, m_gid);
    check("tx_done", tx_done, e_done);
    check("timeout_err", timeout_err, e_to);
    if (tx_start) begin
      check("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) check("tx_data", tx_data, exp_q.pop_front());
    end

    // Advance the model to the next cycle.
    if (!m_active) begin
      if (enable && !tx_busy && (req_valid != '0)) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          idx = (m_rr + k) % N;
          if (!found && req_valid[idx]) begin
            found = 1;
            m_gid = idx;
          end
        end
        exp_q.push_back(req_data[m_gid*DW +: DW]);
        m_rr        = (m_gid + 1) % N;
        m_active    = 1;
        m_age       = 0;
        m_busy_seen = 0;
      end
    end else if (e_done || e_to) begin
      m_active = 0;
    end else begin
      if ((m_age >= 1) && tx_busy) m_busy_seen = 1;
      m_age++;
    end
  endtask

  // Compare process: once per cycle, mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_outputs", {tx_start, req_ready, grant_valid, tx_done, timeout_err,
                            grant_id, tx_data}, '0);
      model_reset();
      s_start = 1'b0;
      s_ready = '0;
    end else begin
      model_cycle();
      if (tx_start) begin
        start_cyc.push_back(cyc);
        start_gid.push_back(int'(grant_id));
        start_dat.push_back(int'(tx_data));
      end
      if (tx_done)     done_cyc.push_back(cyc);
      if (timeout_err) to_cyc.push_back(cyc);
      if (tx_start && tx_busy) overlap_cnt++;
      s_start = tx_start;
      s_ready = req_ready;
    end
  end

  // ---------------- driver ----------------
  bit xm_respond  = 1;   // transmitter answers tx_start with busy
  bit xm_rand     = 0;   // randomize busy delay/length per character
  int xm_d        = 1;   // cycles from tx_start to busy rising
  int xm_len      = 3;   // cycles busy stays high
  int xm_delay    = 0;
  int xm_left     = 0;
  int ext_left    = 0;   // external use of the transmitter
  int ext_rate    = 0;
  int refill_mode = 0;   // 0: drop after accept, 1: keep, 2: random
  int raise_rate  = 0;
  bit rand_enable = 0;

  task automatic step();
    @(posedge clk);
    #1;
    if (s_start && xm_respond)
      xm_delay = xm_rand ? $urandom_range(BT + 1, 1) : xm_d;
    if (s_start && xm_respond && xm_rand) xm_len = $urandom_range(5, 1);
    if (xm_delay > 0) begin
      xm_delay--;
      if (xm_delay == 0) xm_left = xm_len;
    end
    if ((ext_left == 0) && (ext_rate > 0) && (xm_left == 0) && (xm_delay == 0) &&
        ($urandom_range(99, 0) < ext_rate))
      ext_left = $urandom_range(3, 1);
    tx_busy = (xm_left > 0) || (ext_left > 0);
    if (xm_left > 0)  xm_left--;
    if (ext_left > 0) ext_left--;

    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && s_ready[i]) begin
        if (refill_mode == 0) req_valid[i] = 1'b0;
        else if (refill_mode == 2) begin
          if ($urandom_range(1, 0) == 1) req_data[i*DW +: DW] = DW'($urandom);
          else                           req_valid[i] = 1'b0;
        end
      end else if (!req_valid[i] && (raise_rate > 0) &&
                   ($urandom_range(99, 0) < raise_rate)) begin
        req_valid[i] = 1'b1;
        req_data[i*DW +: DW] = DW'($urandom);
      end
    end
    if (rand_enable) enable = ($urandom_range(9, 0) != 0);
  endtask

  task automatic wait_starts(input string name, input int n, input int budget);
    int b;
    b = 0;
    while ((start_cyc.size() < n) && (b < budget)) begin
      step();
      b++;
    end
    check(name, (start_cyc.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_idle(input string name);
    int b;
    b = 0;
    while ((grant_valid !== 1'b0) && (b < 60)) begin
      step();
      b++;
    end
    check(name, grant_valid, 0);
  endtask

  // ---------------- scenarios ----------------
  int c0;
  int nd;

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    tx_busy   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {tx_start, req_ready, grant_valid, tx_done, timeout_err,
                            grant_id, tx_data}, '0);
    check("reset_state", state_dbg, 0);
    rst = 1'b0;

    // Requesters 1 and 3 pending: 1 wins first, then 3.
    clear_logs();
    xm_d = 1; xm_len = 20; refill_mode = 0;
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req_valid = 4'b1010;
    enable    = 1'b1;
    c0        = cyc;
    wait_starts("a_two_starts", 2, 80);
    if (start_cyc.size() >= 2 && done_cyc.size() >= 1) begin
      check("a_latency", start_cyc[0] - c0, 1);
      check("a_gid0", start_gid[0], 1);
      check("a_data0", start_dat[0], 8'hA1);
      check("a_gid1", start_gid[1], 3);
      check("a_data1", start_dat[1], 8'hA3);
      check("a_done_at", done_cyc[0] - start_cyc[0], 21);
      check("a_gap", start_cyc[1] - start_cyc[0], 23);
    end
    wait_idle("a_idle");

    // All four pending continuously: strict rotation.
    clear_logs();
    xm_len = 3; refill_mode = 1; overlap_cnt = 0;
    req_valid = 4'b1111;
    wait_starts("b_five_starts", 5, 200);
    enable = 1'b0;
    wait_idle("b_idle");
    if (start_cyc.size() >= 5) begin
      check("b_gid0", start_gid[0], 0);
      check("b_gid1", start_gid[1], 1);
      check("b_gid2", start_gid[2], 2);
      check("b_gid3", start_gid[3], 3);
      check("b_gid4", start_gid[4], 0);
      check("b_gap", start_cyc[1] - start_cyc[0], 6);
    end
    check("b_start_eq_done", start_cyc.size(), done_cyc.size());
    check("b_overlap", overlap_cnt, 0);

    // Enable dropped while waiting for done: transfer still completes.
    clear_logs();
    xm_len = 10;
    enable = 1'b1;
    wait_starts("c_first", 1, 10);
    repeat (3) step();
    enable = 1'b0;
    repeat (30) step();
    check("c_done", done_cyc.size(), 1);
    check("c_no_start", start_cyc.size(), 1);
    enable = 1'b1;
    repeat (4) step();
    check("c_resume", start_cyc.size(), 2);
    enable = 1'b0;
    wait_idle("c_idle");

    // Transmitter never answers: timeout, then the pending request retries.
    req_valid  = '0;
    xm_respond = 0;
    clear_logs();
    req_valid  = 4'b0100;
    enable     = 1'b1;
    c0         = cyc;
    wait_starts("d_two_starts", 2, 60);
    if (start_cyc.size() >= 2 && to_cyc.size() >= 1) begin
      check("d_latency", start_cyc[0] - c0, 1);
      check("d_timeout_at", to_cyc[0] - start_cyc[0], BT);
      check("d_rearb", start_cyc[1] - to_cyc[0], 2);
      check("d_gid", start_gid[1], 2);
    end
    check("d_no_done", done_cyc.size(), 0);
    enable = 1'b0;
    wait_idle("d_idle");

    // Transmitter busy from outside while idle: no arbitration.
    req_valid  = '0;
    xm_respond = 1; xm_d = 1; xm_len = 2; refill_mode = 0;
    clear_logs();
    tx_busy   = 1'b1;
    ext_left  = 5;
    req_valid = 4'b0001;
    enable    = 1'b1;
    repeat (5) step();
    check("e_blocked", start_cyc.size(), 0);
    wait_starts("e_start", 1, 10);
    if (start_gid.size() >= 1) check("e_gid", start_gid[0], 0);
    enable = 1'b0;
    wait_idle("e_idle");

    // Reset in the middle of requester 2's transfer.
    clear_logs();
    xm_len = 20; refill_mode = 1;
    req_valid = 4'b1111;
    enable    = 1'b1;
    wait_starts("f_two_starts", 2, 60);
    if (start_gid.size() >= 2) check("f_gid_pre", start_gid[1], 2);
    repeat (4) step();
    nd = done_cyc.size();
    #2;
    rst = 1'b1;
    xm_left = 0; xm_delay = 0; ext_left = 0;
    tx_busy = 1'b0;
    #1;
    check("f_rst_outputs", {tx_start, req_ready, grant_valid, tx_done, timeout_err}, 0);
    check("f_rst_gid", grant_id, 0);
    check("f_rst_data", tx_data, 0);
    check("f_rst_state", state_dbg, 0);
    repeat (2) step();
    check("f_no_done", done_cyc.size(), nd);
    clear_logs();
    rst = 1'b0;
    c0  = cyc;
    wait_starts("f_restart", 1, 10);
    if (start_cyc.size() >= 1) begin
      check("f_first_gid", start_gid[0], 0);
      check("f_latency", start_cyc[0] - c0, 1);
    end

    // Randomized traffic, enable, transmitter timing and external busy.
    refill_mode = 2; raise_rate = 15; ext_rate = 3;
    rand_enable = 1; xm_rand = 1;
    repeat (2000) step();
    rand_enable = 0; raise_rate = 0; ext_rate = 0;
    enable = 1'b0;
    wait_idle("g_idle");
    check("g_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
